// File: rtl/seven_seg_scan_drv.sv
// seven_seg_scan_drv: 4-digit common-anode multiplexed scan driver with
// per-frame snapshot, per-slot ghost blanking and per-digit blink.
module seven_seg_scan_drv #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic        hi_sel,
    input  logic        graph_mode,
    input  logic [3:0]  point,
    input  logic [3:0]  blink_en,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          blink_ph_q, blink_ph_d;
    logic          load_q, load_d;
    logic [31:0]   num_q, num_d;
    logic          hi_sel_q, hi_sel_d;
    logic          graph_q, graph_d;
    logic [3:0]    point_q, point_d;
    logic [3:0]    blink_en_q, blink_en_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          slot_end, frame_end, frm_wrap, snap, blank;
    logic [3:0]    nib;

    always_comb begin
        slot_end   = cnt_q == CW'(SCAN_DIV - 1);
        frame_end  = slot_end && dig_q == 2'd3;
        frm_wrap   = frm_q == FW'(BLINK_FRAMES - 1);
        cnt_d      = (load_q || slot_end) ? '0 : cnt_q + CW'(1);
        dig_d      = load_q ? 2'd0 : dig_q + {1'b0, slot_end};
        frm_d      = frame_end ? (frm_wrap ? '0 : frm_q + FW'(1)) : frm_q;
        blink_ph_d = blink_ph_q ^ (frame_end && frm_wrap);
        load_d     = 1'b0;
        snap       = load_q || frame_end;
        num_d      = snap ? disp_num : num_q;
        hi_sel_d   = snap ? hi_sel : hi_sel_q;
        graph_d    = snap ? graph_mode : graph_q;
        point_d    = snap ? point : point_q;
        blink_en_d = snap ? blink_en : blink_en_q;
        // outputs track the post-edge counters and snapshot so there is no lag
        nib        = num_d[{hi_sel_d, dig_d, 2'b00} +: 4];
        blank      = int'(cnt_d) < BLANK_CYC || (blink_en_d[dig_d] && blink_ph_d);
        an_d       = blank ? 4'hF : ~(4'b0001 << dig_d);
        seg_d      = blank ? 8'hFF :
                     graph_d ? num_d[{dig_d, 3'b000} +: 8] : {~point_d[dig_d], HEX[nib]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            dig_q      <= '0;
            frm_q      <= '0;
            blink_ph_q <= 1'b0;
            load_q     <= 1'b1;
            num_q      <= '0;
            hi_sel_q   <= 1'b0;
            graph_q    <= 1'b0;
            point_q    <= '0;
            blink_en_q <= '0;
            an_q       <= 4'hF;
            seg_q      <= 8'hFF;
        end else begin
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            frm_q      <= frm_d;
            blink_ph_q <= blink_ph_d;
            load_q     <= load_d;
            num_q      <= num_d;
            hi_sel_q   <= hi_sel_d;
            graph_q    <= graph_d;
            point_q    <= point_d;
            blink_en_q <= blink_en_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign AN      = an_q;
    assign SEGMENT = seg_q;
endmodule

// File: tb/tb_seven_seg_scan_drv.sv
// tb_seven_seg_scan_drv: directed vector table plus hand sequences for
// reset, blink and snapshot behaviour with SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
module tb_seven_seg_scan_drv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp_num = '0;
    logic        hi_sel = 1'b0;
    logic        graph_mode = 1'b0;
    logic [3:0]  point = '0;
    logic [3:0]  blink_en = '0;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [31:0]     num;
        logic            hi;
        logic            g;
        logic [3:0]      pt;
        logic [3:0][7:0] seg;
    } vec_t;
    vec_t vecs[7];

    seven_seg_scan_drv #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .disp_num(disp_num), .hi_sel(hi_sel),
        .graph_mode(graph_mode), .point(point), .blink_en(blink_en),
        .AN(AN), .SEGMENT(SEGMENT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] ea, input logic [7:0] es);
        n_cmp++;
        if (AN !== ea || SEGMENT !== es) begin
            n_err++;
            $display("FAIL %s: got AN=%b SEG=%h, want AN=%b SEG=%h @%0t", name, AN, SEGMENT, ea, es, $time);
        end
    endtask

    // starts at the sample where the slot's cnt=2, ends at the next slot's cnt=2
    task automatic check_slot(input string name, input int d, input logic [7:0] es, input logic off);
        logic [3:0] ea;
        logic [7:0] ex;
        for (int i = 0; i < 8; i++) begin
            ea = (i < 6 && !off) ? ~(4'b0001 << d) : 4'hF;
            ex = (i < 6 && !off) ? es : 8'hFF;
            chk($sformatf("%s d%0d c%0d", name, d, i + 2), ea, ex);
            @(negedge clk);
        end
    endtask

    task automatic sync_d0;
        int n = 0;
        while (AN == 4'b1110 && n < 100) begin @(negedge clk); n++; end
        while (AN != 4'b1110 && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (n >= 100) begin
            n_err++;
            $display("FAIL sync: got AN=%b, want digit 0 drive within 100 cycles", AN);
        end
    endtask

    task automatic apply(input vec_t v);
        disp_num   = v.num;
        hi_sel     = v.hi;
        graph_mode = v.g;
        point      = v.pt;
    endtask

    initial begin
        vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0, 4'h0, {8'h88, 8'h83, 8'hC6, 8'hA1}};
        vecs[1] = '{32'h1234ABCD, 1'b1, 1'b0, 4'h0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[2] = '{32'hFE7F00FF, 1'b0, 1'b1, 4'hF, {8'hFE, 8'h7F, 8'h00, 8'hFF}};
        vecs[3] = '{32'h1234ABCD, 1'b0, 1'b0, 4'hA, {8'h08, 8'h83, 8'h46, 8'hA1}};
        vecs[4] = '{32'h89EF5670, 1'b0, 1'b0, 4'h0, {8'h92, 8'h82, 8'hF8, 8'hC0}};
        vecs[5] = '{32'h89EF5670, 1'b1, 1'b0, 4'hF, {8'h00, 8'h10, 8'h06, 8'h0E}};
        vecs[6] = '{32'hFE7F00FF, 1'b1, 1'b1, 4'h0, {8'hFE, 8'h7F, 8'h00, 8'hFF}};

        apply(vecs[0]);
        repeat (3) @(negedge clk);
        chk("reset held", 4'hF, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        chk("load edge c0", 4'hF, 8'hFF);
        @(negedge clk);
        chk("post load c1", 4'hF, 8'hFF);
        @(negedge clk);
        chk("first drive c2", 4'b1110, 8'hA1);
        repeat (2) @(negedge clk);
        chk("pre async reset", 4'b1110, 8'hA1);
        #2 rst = 1'b1;
        blink_en = 4'b0100;
        #1 chk("async reset", 4'hF, 8'hFF);
        @(negedge clk);
        rst = 1'b0;

        // frames counted from reset release: digit 2 on for 2 frames, off for 2
        sync_d0();
        for (int f = 0; f < 8; f++)
            for (int d = 0; d < 4; d++)
                check_slot($sformatf("blink f%0d", f), d, vecs[0].seg[d], d == 2 && ((f / 2) % 2 == 1));
        blink_en = 4'b0000;

        foreach (vecs[k]) begin
            apply(vecs[k]);
            sync_d0();
            sync_d0();
            for (int d = 0; d < 4; d++)
                check_slot($sformatf("vec%0d", k), d, vecs[k].seg[d], 1'b0);
        end

        apply(vecs[0]);
        sync_d0();
        sync_d0();
        check_slot("snap old", 0, 8'hA1, 1'b0);
        disp_num = 32'h89EF5670;
        check_slot("snap old", 1, 8'hC6, 1'b0);
        check_slot("snap old", 2, 8'h83, 1'b0);
        check_slot("snap old", 3, 8'h88, 1'b0);
        for (int d = 0; d < 4; d++)
            check_slot("snap new", d, vecs[4].seg[d], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
